// File: rtl/mavg_pkg.sv
// Shared types and width helpers for the three-channel moving-average scheduler.
package mavg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPD_X,
    S_UPD_Y,
    S_UPD_T,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_X,
    CH_Y,
    CH_T
  } ch_t;

  function automatic int calc_sum_w(input int data_w, input int window_size);
    return data_w + $clog2(window_size);
  endfunction

  function automatic int calc_fill_w(input int window_size);
    return $clog2(window_size) + 1;
  endfunction

endpackage

// File: rtl/mavg_hist.sv
// One-channel circular window history: combinational read and single write at the same pointer.
module mavg_hist #(
  parameter  int WINDOW_SIZE = 4,
  parameter  int DATA_W      = 2,
  localparam int PTR_W       = $clog2(WINDOW_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [WINDOW_SIZE];

  // Zeroed history keeps the running sum equal to the samples seen so far during warm-up.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < WINDOW_SIZE; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/mavg_sched.sv
// Three-channel moving-average sequencer: one shared add/subtract unit stepped over x, y, t by a small FSM.
module mavg_sched
  import mavg_pkg::*;
#(
  parameter  int WINDOW_SIZE = 4,
  parameter  int DATA_W      = 2,
  localparam int SUM_W       = calc_sum_w(DATA_W, WINDOW_SIZE),
  localparam int FILL_W      = calc_fill_w(WINDOW_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_t,
  input  logic              out_en,
  output logic              out_valid,
  output logic [SUM_W-1:0]  sum_x,
  output logic [SUM_W-1:0]  sum_y,
  output logic [SUM_W-1:0]  sum_t,
  output logic [DATA_W-1:0] avg_x,
  output logic [DATA_W-1:0] avg_y,
  output logic [DATA_W-1:0] avg_t,
  output logic [FILL_W-1:0] fill,
  output logic              full
);

  localparam int PTR_W = $clog2(WINDOW_SIZE);

  state_t            state, state_nxt;
  ch_t               ch_sel;
  logic [DATA_W-1:0] smp_x, smp_y, smp_t;
  logic [DATA_W-1:0] old_x, old_y, old_t;
  logic [PTR_W-1:0]  wr_ptr;
  logic [SUM_W-1:0]  sum_sel, add_res;
  logic [DATA_W-1:0] new_sel, old_sel;
  logic              accept;

  assign accept    = (state == S_IDLE) && in_valid;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign full      = (fill == FILL_W'(WINDOW_SIZE));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nxt = S_UPD_X;
      S_UPD_X: state_nxt = S_UPD_Y;
      S_UPD_Y: state_nxt = S_UPD_T;
      S_UPD_T: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample register: only loaded on an accepted handshake that is not being flushed.
  always_ff @(posedge clk) begin
    if (accept && !clr) begin
      smp_x <= in_x;
      smp_y <= in_y;
      smp_t <= in_t;
    end
  end

  always_comb begin
    ch_sel = CH_X;
    unique case (state)
      S_UPD_Y: ch_sel = CH_Y;
      S_UPD_T: ch_sel = CH_T;
      default: ch_sel = CH_X;
    endcase
  end

  always_comb begin
    sum_sel = sum_x;
    new_sel = smp_x;
    old_sel = old_x;
    unique case (ch_sel)
      CH_Y: begin
        sum_sel = sum_y;
        new_sel = smp_y;
        old_sel = old_y;
      end
      CH_T: begin
        sum_sel = sum_t;
        new_sel = smp_t;
        old_sel = old_t;
      end
      default: ;
    endcase
  end

  // The sum always contains the outgoing history entry, so the subtraction never wraps.
  assign add_res = sum_sel + SUM_W'(new_sel) - SUM_W'(old_sel);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_t  <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      unique case (state)
        S_UPD_X: sum_x <= add_res;
        S_UPD_Y: sum_y <= add_res;
        S_UPD_T: begin
          sum_t  <= add_res;
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (!full) fill <= fill + FILL_W'(1);
        end
        default: ;
      endcase
    end
  end

  mavg_hist #(.WINDOW_SIZE(WINDOW_SIZE), .DATA_W(DATA_W)) u_hist_x (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(state == S_UPD_X),
    .wr_ptr(wr_ptr), .wr_data(smp_x), .rd_data(old_x)
  );

  mavg_hist #(.WINDOW_SIZE(WINDOW_SIZE), .DATA_W(DATA_W)) u_hist_y (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(state == S_UPD_Y),
    .wr_ptr(wr_ptr), .wr_data(smp_y), .rd_data(old_y)
  );

  mavg_hist #(.WINDOW_SIZE(WINDOW_SIZE), .DATA_W(DATA_W)) u_hist_t (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(state == S_UPD_T),
    .wr_ptr(wr_ptr), .wr_data(smp_t), .rd_data(old_t)
  );

  // Averages are a plain shift of the sums; warm-up values are not re-normalised.
  assign avg_x = out_en ? sum_x[SUM_W-1:PTR_W] : '0;
  assign avg_y = out_en ? sum_y[SUM_W-1:PTR_W] : '0;
  assign avg_t = out_en ? sum_t[SUM_W-1:PTR_W] : '0;

endmodule

// File: tb/tb_mavg_sched.sv
// Self-checking bench for mavg_sched: vector table, hand-written corner sequences and a randomized model run.
module tb_mavg_sched;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, out_en, out_valid, full;
  logic [1:0] in_x, in_y, in_t, avg_x, avg_y, avg_t;
  logic [3:0] sum_x, sum_y, sum_t;
  logic [2:0] fill;

  int checks   = 0;
  int failures = 0;
  int qx[$], qy[$], qt[$];

  typedef struct {
    int x, y, t, en;
    int sx, sy, st, ax, ay, at, fl, fu;
  } vec_t;
  vec_t vecs[9];

  mavg_sched dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_t(in_t), .out_en(out_en), .out_valid(out_valid),
    .sum_x(sum_x), .sum_y(sum_y), .sum_t(sum_t),
    .avg_x(avg_x), .avg_y(avg_y), .avg_t(avg_t), .fill(fill), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_push(input int x, input int y, input int t);
    qx.push_back(x); qy.push_back(y); qt.push_back(t);
    if (qx.size() > 4) begin
      void'(qx.pop_front()); void'(qy.pop_front()); void'(qt.pop_front());
    end
  endtask

  task automatic model_clear();
    qx.delete(); qy.delete(); qt.delete();
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, "_sum_x"}, int'(sum_x), qsum(qx));
    chk({tag, "_sum_y"}, int'(sum_y), qsum(qy));
    chk({tag, "_sum_t"}, int'(sum_t), qsum(qt));
    chk({tag, "_avg_x"}, int'(avg_x), out_en ? qsum(qx) / 4 : 0);
    chk({tag, "_avg_y"}, int'(avg_y), out_en ? qsum(qy) / 4 : 0);
    chk({tag, "_avg_t"}, int'(avg_t), out_en ? qsum(qt) / 4 : 0);
    chk({tag, "_fill"},  int'(fill),  qx.size());
    chk({tag, "_full"},  int'(full),  (qx.size() == 4) ? 1 : 0);
  endtask

  // Starts and ends on a falling edge; returns in the cycle after the out_valid strobe.
  task automatic send(input int x, input int y, input int t);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(in_ready), 1);
    in_x = 2'(x); in_y = 2'(y); in_t = 2'(t);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("busy_ready", int'(in_ready), 0);
      chk("strobe", int'(out_valid), (k == 4) ? 1 : 0);
      @(negedge clk);
    end
    chk("ready_back", int'(in_ready), 1);
    chk("strobe_end", int'(out_valid), 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3,1,2,1,  3,1,2, 0,0,0, 1,0};
    vecs[1] = '{3,1,2,1,  6,2,4, 1,0,1, 2,0};
    vecs[2] = '{3,1,2,1,  9,3,6, 2,0,1, 3,0};
    vecs[3] = '{3,1,2,1, 12,4,8, 3,1,2, 4,1};
    vecs[4] = '{3,1,2,1, 12,4,8, 3,1,2, 4,1};
    vecs[5] = '{0,1,2,1,  9,4,8, 2,1,2, 4,1};
    vecs[6] = '{0,1,2,1,  6,4,8, 1,1,2, 4,1};
    vecs[7] = '{0,1,2,1,  3,4,8, 0,1,2, 4,1};
    vecs[8] = '{0,1,2,1,  0,4,8, 0,1,2, 4,1};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_en = 1'b1;
    in_x = '0; in_y = '0; in_t = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_strobe", int'(out_valid), 0);
    chk("rst_sum_x", int'(sum_x), 0);
    chk("rst_sum_t", int'(sum_t), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_full", int'(full), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Per-stage latency of the first sample.
    in_x = 2'd3; in_y = 2'd1; in_t = 2'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_ready", int'(in_ready), 0);
    chk("lat1_strobe", int'(out_valid), 0);
    chk("lat1_sum_x", int'(sum_x), 0);
    @(negedge clk);
    chk("lat2_strobe", int'(out_valid), 0);
    chk("lat2_sum_x", int'(sum_x), 3);
    chk("lat2_sum_y", int'(sum_y), 0);
    @(negedge clk);
    chk("lat3_ready", int'(in_ready), 0);
    chk("lat3_sum_y", int'(sum_y), 1);
    chk("lat3_sum_t", int'(sum_t), 0);
    chk("lat3_fill", int'(fill), 0);
    @(negedge clk);
    chk("lat4_ready", int'(in_ready), 0);
    chk("lat4_strobe", int'(out_valid), 1);
    chk("lat4_sum_t", int'(sum_t), 2);
    chk("lat4_fill", int'(fill), 1);
    @(negedge clk);
    chk("lat5_ready", int'(in_ready), 1);
    chk("lat5_strobe", int'(out_valid), 0);

    // Fill, saturation, slide and wrap from an empty window.
    pulse_clr();
    chk("clr_sum_x", int'(sum_x), 0);
    chk("clr_fill", int'(fill), 0);
    for (int i = 0; i < 9; i++) begin
      out_en = vecs[i].en[0];
      send(vecs[i].x, vecs[i].y, vecs[i].t);
      chk($sformatf("vec%0d_sum_x", i), int'(sum_x), vecs[i].sx);
      chk($sformatf("vec%0d_sum_y", i), int'(sum_y), vecs[i].sy);
      chk($sformatf("vec%0d_sum_t", i), int'(sum_t), vecs[i].st);
      chk($sformatf("vec%0d_avg_x", i), int'(avg_x), vecs[i].ax);
      chk($sformatf("vec%0d_avg_y", i), int'(avg_y), vecs[i].ay);
      chk($sformatf("vec%0d_avg_t", i), int'(avg_t), vecs[i].at);
      chk($sformatf("vec%0d_fill", i), int'(fill), vecs[i].fl);
      chk($sformatf("vec%0d_full", i), int'(full), vecs[i].fu);
    end

    // Output gating only masks the averages, and reacts combinationally.
    pulse_clr();
    out_en = 1'b0;
    repeat (4) send(3, 3, 3);
    chk("gate_avg_x", int'(avg_x), 0);
    chk("gate_sum_x", int'(sum_x), 12);
    out_en = 1'b1;
    #1;
    chk("ungate_avg_x", int'(avg_x), 3);
    chk("ungate_sum_x", int'(sum_x), 12);
    @(negedge clk);

    // Flush during UPD_Y drops the in-flight sample.
    pulse_clr();
    send(2, 2, 2);
    in_x = 2'd3; in_y = 2'd3; in_t = 2'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_mid_sum_x", int'(sum_x), 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    chk("flush_sum_x", int'(sum_x), 0);
    chk("flush_sum_y", int'(sum_y), 0);
    chk("flush_sum_t", int'(sum_t), 0);
    chk("flush_fill", int'(fill), 0);
    chk("flush_ready", int'(in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      chk("flush_no_strobe", int'(out_valid), 0);
      @(negedge clk);
    end
    send(1, 1, 1);
    model_push(1, 1, 1);
    model_cmp("post_flush");

    // clr beats in_valid in the same idle cycle.
    clr = 1'b1; in_valid = 1'b1; in_x = 2'd2;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      chk("clrwin_ready", int'(in_ready), 1);
      chk("clrwin_strobe", int'(out_valid), 0);
      @(negedge clk);
    end
    chk("clrwin_fill", int'(fill), 0);
    chk("clrwin_sum_x", int'(sum_x), 0);

    // Randomized run against the window model.
    for (int i = 0; i < 40; i++) begin
      int x, y, t;
      if ($urandom_range(0, 9) == 0) begin
        pulse_clr();
        chk("rnd_clr_fill", int'(fill), 0);
      end
      out_en = 1'($urandom_range(0, 1));
      x = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      t = $urandom_range(0, 3);
      send(x, y, t);
      model_push(x, y, t);
      model_cmp($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
